riscv_nn_hwloop_regs: RTL and testbench
=======================================

// Module: riscv_nn_hwloop_regs
// PURPOSE
//  Hardware-loop register file: the state-holding side of the hwloop controller interface.
//  Holds per-loop start address, end address and iteration counter. Written by ID-stage lp.* instructions.
//  Counters are decremented on the controller's hwlp_dec_cnt requests.
//  Returns a registered decrement-in-flight flag to the controller.
// PARAMETERS
//  N_REGS      2   number of hardware loops (index 0 = highest priority, innermost)
//  N_REG_BITS  1   width of loop select index, $clog2(N_REGS), min 1
// PORTS
//  clk                  in   1            clock, all state updates on rising edge
//  rst                  in   1            synchronous reset, active-high
//  hwlp_start_data_i    in   32           start address write data
//  hwlp_end_data_i      in   32           end address write data
//  hwlp_cnt_data_i      in   32           counter write data
//  hwlp_we_i            in   3            write enables: [0]=start, [1]=end, [2]=counter
//  hwlp_regid_i         in   N_REG_BITS   loop index targeted by hwlp_we_i
//  valid_i              in   1            ID stage accepts current instruction; gates decrements
//  hwlp_dec_cnt_i       in   N_REGS       one-hot decrement request from controller
//  hwlp_start_addr_o    out  N_REGS*32    per-loop start address
//  hwlp_end_addr_o      out  N_REGS*32    per-loop end address
//  hwlp_counter_o       out  N_REGS*32    per-loop remaining iteration count
//  hwlp_dec_cnt_id_o    out  N_REGS       decrement applied last cycle (in flight)
//  hwlp_active_o        out  N_REGS       counter != 0 for that loop
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain, clk.
//  - rst is synchronous and active-high. While rst=1 at a rising edge, all start, end and counter registers clear to 0.
//  - Reset also clears hwlp_dec_cnt_id_o and hwlp_active_o to 0 and overrides any concurrent write or decrement.
//  Latency
//  - All outputs are driven directly from registers.
//  - A write or decrement at edge k is visible on the outputs after edge k.
//  - No combinational path from any input to any output.
//  Writes
//  - Per field, each we bit independently updates the field of loop hwlp_regid_i.
//  - Multiple we bits in one cycle update all the selected fields.
//  - hwlp_regid_i >= N_REGS (non-power-of-2 N_REGS) is ignored: no state change.
//  - Writes do not depend on valid_i. ID asserts we only for accepted instructions.
//  Decrement
//  - Loop i counter <= counter-1 when valid_i & hwlp_dec_cnt_i[i].
//  - Counter saturates at 0: a decrement at 0 leaves it 0, never 32'hFFFFFFFF.
//  - hwlp_dec_cnt_i is one-hot from the controller.
//    If more than one bit is set, every flagged loop decrements; no error is raised.
//  Simultaneous write and decrement
//  - Counter write (we[2]) to loop i in the same cycle as a decrement of loop i: the write wins.
//    The counter is loaded with hwlp_cnt_data_i, not data-1.
//  - Write to loop i and decrement of loop j (j != i): both take effect.
//  In-flight flag
//  - hwlp_dec_cnt_id_o[i] <= valid_i & hwlp_dec_cnt_i[i] & ~(we[2] & regid==i).
//  - The flag lasts one cycle per applied decrement.
//  - The controller uses it to suppress a second jump while counter==2.
//  Active flag
//  - hwlp_active_o[i] <= (next counter value != 0).
//  - It is registered alongside the counter and always equals (hwlp_counter_o[i] != 0).
//  No FSM beyond the per-loop registers. Expected size is about 150 lines.
// TESTING
//  1. Reset behaviour
//     Drive rst=1 for 2 cycles with we=3'b111 and dec=all-ones.
//     -> All outputs are 0 after the 2nd edge.
//  2. Writes to loop 1
//     Write start=0x100, end=0x120, cnt=5 to loop 1 (we=3'b111).
//     -> The next cycle shows start[1]=0x100, end[1]=0x120, counter[1]=5 and active[1]=1. Loop 0 is unchanged.
//  3. Decrement gating and saturation
//     Load counter[0]=2, then assert dec=2'b01 with valid_i=1 for 3 cycles.
//     -> counter[0] goes 1, 0, 0.
//     -> dec_cnt_id[0] is 1 on every cycle following an applied decrement.
//     -> active[0] drops when the counter reaches 0.
//     With valid_i=0 the counter holds.
//  4. Same-loop collision
//     Counter[0]=7. In the same cycle write cnt=3 to loop 0 and assert dec=2'b01, valid_i=1.
//     -> counter[0]=3 and dec_cnt_id[0]=0.
//  5. Cross-loop concurrency
//     Write cnt=9 to loop 1 while decrementing loop 0 (counter 4).
//     -> counter[1]=9 and counter[0]=3 after one edge.
//  6. Reset mid-loop
//     counter[0]=10 with decrements ongoing. Assert rst for one cycle.
//     -> counter[0]=0 and dec_cnt_id=0 next cycle. A decrement in the cycle after reset leaves 0.

Source files
------------

// File: rtl/riscv_nn_hwloop_regs.sv
// Hardware-loop register file.
//
// Holds the start address, end address and remaining iteration count of
// each hardware loop. The ID stage writes these registers with lp.*
// instructions. The loop controller requests counter decrements. Every
// output comes straight from a flop, so no input reaches an output
// combinationally.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   hwlp_*_data_i       write data for the start, end and counter fields
//   hwlp_we_i           field write enables {cnt, end, start}
//   hwlp_regid_i        loop targeted by the write; out-of-range ids are ignored
//   valid_i             qualifies the decrement requests
//   hwlp_dec_cnt_i      per-loop decrement request (normally one-hot)
//   hwlp_start_addr_o   per-loop start address, loop i at [i*32 +: 32]
//   hwlp_end_addr_o     per-loop end address
//   hwlp_counter_o      per-loop remaining iterations
//   hwlp_dec_cnt_id_o   a decrement was taken on the previous edge
//   hwlp_active_o       per-loop (counter != 0)

module riscv_nn_hwloop_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [2:0]  we,
  input  logic [31:0] start_data,
  input  logic [31:0] end_data,
  input  logic [31:0] cnt_data,
  input  logic        dec,
  output logic [31:0] start_addr,
  output logic [31:0] end_addr,
  output logic [31:0] counter,
  output logic        dec_id,
  output logic        active
);

  logic        cnt_wr;
  logic [31:0] cnt_nxt;

  assign cnt_wr = sel & we[2];

  // A counter write beats a decrement of the same loop. A decrement at 0 saturates.
  always_comb begin
    cnt_nxt = counter;
    if (cnt_wr)                        cnt_nxt = cnt_data;
    else if (dec && counter != 32'd0)  cnt_nxt = counter - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr <= '0;
      end_addr   <= '0;
      counter    <= '0;
      dec_id     <= 1'b0;
      active     <= 1'b0;
    end else begin
      if (sel && we[0]) start_addr <= start_data;
      if (sel && we[1]) end_addr   <= end_data;
      counter <= cnt_nxt;
      dec_id  <= dec & ~cnt_wr;
      // Registered with the counter so it always matches (counter != 0).
      active  <= (cnt_nxt != 32'd0);
    end
  end

endmodule

module riscv_nn_hwloop_regs #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            hwlp_start_data_i,
  input  logic [31:0]            hwlp_end_data_i,
  input  logic [31:0]            hwlp_cnt_data_i,
  input  logic [2:0]             hwlp_we_i,
  input  logic [N_REG_BITS-1:0]  hwlp_regid_i,
  input  logic                   valid_i,
  input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
  output logic [N_REGS*32-1:0]   hwlp_start_addr_o,
  output logic [N_REGS*32-1:0]   hwlp_end_addr_o,
  output logic [N_REGS*32-1:0]   hwlp_counter_o,
  output logic [N_REGS-1:0]      hwlp_dec_cnt_id_o,
  output logic [N_REGS-1:0]      hwlp_active_o
);

  logic [N_REGS-1:0] sel;
  logic [N_REGS-1:0] dec;

  for (genvar i = 0; i < N_REGS; i++) begin : g_lane
    // An id outside 0..N_REGS-1 matches no lane, so that write is dropped.
    assign sel[i] = (hwlp_regid_i == N_REG_BITS'(i));
    assign dec[i] = valid_i & hwlp_dec_cnt_i[i];

    riscv_nn_hwloop_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel[i]),
      .we         (hwlp_we_i),
      .start_data (hwlp_start_data_i),
      .end_data   (hwlp_end_data_i),
      .cnt_data   (hwlp_cnt_data_i),
      .dec        (dec[i]),
      .start_addr (hwlp_start_addr_o[i*32 +: 32]),
      .end_addr   (hwlp_end_addr_o[i*32 +: 32]),
      .counter    (hwlp_counter_o[i*32 +: 32]),
      .dec_id     (hwlp_dec_cnt_id_o[i]),
      .active     (hwlp_active_o[i])
    );
  end

endmodule

// File: tb/tb_riscv_nn_hwloop_regs.sv
module tb_riscv_nn_hwloop_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sd, ed, cd;
  logic [2:0]  we;
  logic [0:0]  regid;
  logic        valid;
  logic [1:0]  dec;
  logic [63:0] st_o, en_o, cnt_o;
  logic [1:0]  decid_o, act_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_nn_hwloop_regs #(.N_REGS(2), .N_REG_BITS(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_start_data_i (sd),
    .hwlp_end_data_i   (ed),
    .hwlp_cnt_data_i   (cd),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .valid_i           (valid),
    .hwlp_dec_cnt_i    (dec),
    .hwlp_start_addr_o (st_o),
    .hwlp_end_addr_o   (en_o),
    .hwlp_counter_o    (cnt_o),
    .hwlp_dec_cnt_id_o (decid_o),
    .hwlp_active_o     (act_o)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  we;
    logic        regid;
    logic [31:0] sd, ed, cd;
    logic        valid;
    logic [1:0]  dec;
  } stim_t;

  // Expected outputs after the edge. Each 64-bit field is {loop1, loop0}.
  typedef struct {
    string       tag;
    logic [63:0] st, en, cnt;
    logic [1:0]  decid, act;
  } exp_t;

  stim_t stq[$];
  exp_t  sbq[$];

  function automatic stim_t s(logic r, logic [2:0] w, logic id, logic [31:0] a, logic [31:0] b,
                              logic [31:0] c, logic v, logic [1:0] d);
    stim_t t;
    t.rst = r; t.we = w; t.regid = id; t.sd = a; t.ed = b; t.cd = c; t.valid = v; t.dec = d;
    return t;
  endfunction

  function automatic exp_t e(string tag, logic [63:0] st, logic [63:0] en, logic [63:0] cnt,
                             logic [1:0] dd, logic [1:0] aa);
    exp_t x;
    x.tag = tag; x.st = st; x.en = en; x.cnt = cnt; x.decid = dd; x.act = aa;
    return x;
  endfunction

  task automatic drive(stim_t t);
    rst = t.rst; we = t.we; regid = t.regid; sd = t.sd; ed = t.ed; cd = t.cd;
    valid = t.valid; dec = t.dec;
  endtask

  task automatic idle();
    drive(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00));
  endtask

  localparam logic [63:0] ST = {32'h100, 32'h40};
  localparam logic [63:0] EN = {32'h120, 32'h0};

  task automatic test_reset();
    stq.push_back(s(1'b1, 3'b111, 1'b1, 32'hAAAA, 32'hBBBB, 32'h55, 1'b1, 2'b11));
    sbq.push_back(e("reset_edge1", 64'h0, 64'h0, 64'h0, 2'b00, 2'b00));
    stq.push_back(s(1'b1, 3'b111, 1'b0, 32'hAAAA, 32'hBBBB, 32'h55, 1'b1, 2'b11));
    sbq.push_back(e("reset_edge2", 64'h0, 64'h0, 64'h0, 2'b00, 2'b00));
    while (stq.size() > 0) begin
      exp_t x;
      drive(stq.pop_front());
      @(posedge clk); #1;
      x = sbq.pop_front();
      n_checks++;
      if ({st_o, en_o} !== {x.st, x.en}) begin
        n_fail++; $display("FAIL %s addr: got st=%h en=%h want st=%h en=%h", x.tag, st_o, en_o, x.st, x.en);
      end
      n_checks++;
      if (cnt_o !== x.cnt) begin
        n_fail++; $display("FAIL %s cnt: got %h want %h", x.tag, cnt_o, x.cnt);
      end
      n_checks++;
      if ({decid_o, act_o} !== {x.decid, x.act}) begin
        n_fail++; $display("FAIL %s flags: got dec_id=%b act=%b want dec_id=%b act=%b",
                           x.tag, decid_o, act_o, x.decid, x.act);
      end
    end
    idle();
  endtask

  task automatic test_writes();
    stq.push_back(s(1'b0, 3'b111, 1'b1, 32'h100, 32'h120, 32'd5, 1'b0, 2'b00));
    sbq.push_back(e("write_loop1", {32'h100, 32'h0}, EN, {32'd5, 32'd0}, 2'b00, 2'b10));
    // Only the start field of loop 0; the counter data is ignored.
    stq.push_back(s(1'b0, 3'b001, 1'b0, 32'h40, 32'hDEAD, 32'hBEEF, 1'b0, 2'b00));
    sbq.push_back(e("write_start_only", ST, EN, {32'd5, 32'd0}, 2'b00, 2'b10));
    while (stq.size() > 0) begin
      exp_t x;
      drive(stq.pop_front());
      @(posedge clk); #1;
      x = sbq.pop_front();
      n_checks++;
      if ({st_o, en_o} !== {x.st, x.en}) begin
        n_fail++; $display("FAIL %s addr: got st=%h en=%h want st=%h en=%h", x.tag, st_o, en_o, x.st, x.en);
      end
      n_checks++;
      if (cnt_o !== x.cnt) begin
        n_fail++; $display("FAIL %s cnt: got %h want %h", x.tag, cnt_o, x.cnt);
      end
      n_checks++;
      if ({decid_o, act_o} !== {x.decid, x.act}) begin
        n_fail++; $display("FAIL %s flags: got dec_id=%b act=%b want dec_id=%b act=%b",
                           x.tag, decid_o, act_o, x.decid, x.act);
      end
    end
    idle();
  endtask

  task automatic test_decrement();
    stq.push_back(s(1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd2, 1'b0, 2'b00));
    sbq.push_back(e("dec_load2", ST, EN, {32'd5, 32'd2}, 2'b00, 2'b11));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("dec_to1", ST, EN, {32'd5, 32'd1}, 2'b01, 2'b11));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("dec_to0", ST, EN, {32'd5, 32'd0}, 2'b01, 2'b10));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("dec_saturate", ST, EN, {32'd5, 32'd0}, 2'b01, 2'b10));
    stq.push_back(s(1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd6, 1'b0, 2'b00));
    sbq.push_back(e("dec_load6", ST, EN, {32'd5, 32'd6}, 2'b00, 2'b11));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01));
    sbq.push_back(e("dec_novalid1", ST, EN, {32'd5, 32'd6}, 2'b00, 2'b11));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01));
    sbq.push_back(e("dec_novalid2", ST, EN, {32'd5, 32'd6}, 2'b00, 2'b11));
    while (stq.size() > 0) begin
      exp_t x;
      drive(stq.pop_front());
      @(posedge clk); #1;
      x = sbq.pop_front();
      n_checks++;
      if ({st_o, en_o} !== {x.st, x.en}) begin
        n_fail++; $display("FAIL %s addr: got st=%h en=%h want st=%h en=%h", x.tag, st_o, en_o, x.st, x.en);
      end
      n_checks++;
      if (cnt_o !== x.cnt) begin
        n_fail++; $display("FAIL %s cnt: got %h want %h", x.tag, cnt_o, x.cnt);
      end
      n_checks++;
      if ({decid_o, act_o} !== {x.decid, x.act}) begin
        n_fail++; $display("FAIL %s flags: got dec_id=%b act=%b want dec_id=%b act=%b",
                           x.tag, decid_o, act_o, x.decid, x.act);
      end
    end
    idle();
  endtask

  task automatic test_collision();
    stq.push_back(s(1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd7, 1'b0, 2'b00));
    sbq.push_back(e("coll_load7", ST, EN, {32'd5, 32'd7}, 2'b00, 2'b11));
    stq.push_back(s(1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd3, 1'b1, 2'b01));
    sbq.push_back(e("coll_write_wins", ST, EN, {32'd5, 32'd3}, 2'b00, 2'b11));
    while (stq.size() > 0) begin
      exp_t x;
      drive(stq.pop_front());
      @(posedge clk); #1;
      x = sbq.pop_front();
      n_checks++;
      if ({st_o, en_o} !== {x.st, x.en}) begin
        n_fail++; $display("FAIL %s addr: got st=%h en=%h want st=%h en=%h", x.tag, st_o, en_o, x.st, x.en);
      end
      n_checks++;
      if (cnt_o !== x.cnt) begin
        n_fail++; $display("FAIL %s cnt: got %h want %h", x.tag, cnt_o, x.cnt);
      end
      n_checks++;
      if ({decid_o, act_o} !== {x.decid, x.act}) begin
        n_fail++; $display("FAIL %s flags: got dec_id=%b act=%b want dec_id=%b act=%b",
                           x.tag, decid_o, act_o, x.decid, x.act);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    stq.push_back(s(1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd4, 1'b0, 2'b00));
    sbq.push_back(e("cross_load4", ST, EN, {32'd5, 32'd4}, 2'b00, 2'b11));
    stq.push_back(s(1'b0, 3'b100, 1'b1, 32'h0, 32'h0, 32'd9, 1'b1, 2'b01));
    sbq.push_back(e("cross_wr1_dec0", ST, EN, {32'd9, 32'd3}, 2'b01, 2'b11));
    // Multi-hot request: both loops decrement.
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b11));
    sbq.push_back(e("dec_both", ST, EN, {32'd8, 32'd2}, 2'b11, 2'b11));
    while (stq.size() > 0) begin
      exp_t x;
      drive(stq.pop_front());
      @(posedge clk); #1;
      x = sbq.pop_front();
      n_checks++;
      if ({st_o, en_o} !== {x.st, x.en}) begin
        n_fail++; $display("FAIL %s addr: got st=%h en=%h want st=%h en=%h", x.tag, st_o, en_o, x.st, x.en);
      end
      n_checks++;
      if (cnt_o !== x.cnt) begin
        n_fail++; $display("FAIL %s cnt: got %h want %h", x.tag, cnt_o, x.cnt);
      end
      n_checks++;
      if ({decid_o, act_o} !== {x.decid, x.act}) begin
        n_fail++; $display("FAIL %s flags: got dec_id=%b act=%b want dec_id=%b act=%b",
                           x.tag, decid_o, act_o, x.decid, x.act);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_loop();
    stq.push_back(s(1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd10, 1'b0, 2'b00));
    sbq.push_back(e("mid_load10", ST, EN, {32'd8, 32'd10}, 2'b00, 2'b11));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("mid_dec9", ST, EN, {32'd8, 32'd9}, 2'b01, 2'b11));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("mid_dec8", ST, EN, {32'd8, 32'd8}, 2'b01, 2'b11));
    stq.push_back(s(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("mid_reset", 64'h0, 64'h0, 64'h0, 2'b00, 2'b00));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01));
    sbq.push_back(e("post_reset_dec", 64'h0, 64'h0, 64'h0, 2'b01, 2'b00));
    stq.push_back(s(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00));
    sbq.push_back(e("post_reset_idle", 64'h0, 64'h0, 64'h0, 2'b00, 2'b00));
    while (stq.size() > 0) begin
      exp_t x;
      drive(stq.pop_front());
      @(posedge clk); #1;
      x = sbq.pop_front();
      n_checks++;
      if ({st_o, en_o} !== {x.st, x.en}) begin
        n_fail++; $display("FAIL %s addr: got st=%h en=%h want st=%h en=%h", x.tag, st_o, en_o, x.st, x.en);
      end
      n_checks++;
      if (cnt_o !== x.cnt) begin
        n_fail++; $display("FAIL %s cnt: got %h want %h", x.tag, cnt_o, x.cnt);
      end
      n_checks++;
      if ({decid_o, act_o} !== {x.decid, x.act}) begin
        n_fail++; $display("FAIL %s flags: got dec_id=%b act=%b want dec_id=%b act=%b",
                           x.tag, decid_o, act_o, x.decid, x.act);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_writes();
    test_decrement();
    test_collision();
    test_back_to_back();
    test_reset_mid_loop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
